// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: pipelines the destination index alongside the ALU's registered result
// and shares the register-file write port with load returns through a 1-entry hold buffer.
module alu_writeback #(
  parameter int BITS  = 16,
  parameter int RBITS = 4
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  logic [RBITS-1:0] issue_rd,
  input  logic [BITS-1:0]  alu_out,
  input  logic             mem_valid,
  input  logic [RBITS-1:0] mem_rd,
  input  logic [BITS-1:0]  mem_data,
  output logic             rf_we,
  output logic [RBITS-1:0] rf_waddr,
  output logic [BITS-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [RBITS-1:0] fwd_reg,
  output logic [BITS-1:0]  fwd_data,
  output logic             stall,
  output logic             overflow
);

  typedef enum logic {EMPTY, HELD} hold_state_t;

  hold_state_t      state_q, state_d;
  logic             e1_valid_q, e1_valid_d;
  logic [RBITS-1:0] e1_rd_q, e1_rd_d;
  logic [RBITS-1:0] hold_rd_q, hold_rd_d;
  logic [BITS-1:0]  hold_data_q, hold_data_d;
  logic             rf_we_q, rf_we_d;
  logic [RBITS-1:0] rf_waddr_q, rf_waddr_d;
  logic [BITS-1:0]  rf_wdata_q, rf_wdata_d;
  logic             overflow_q, overflow_d;

  assign stall = (state_q == HELD);

  always_comb begin
    e1_valid_d  = issue_valid & issue_wen & ~stall;
    e1_rd_d     = issue_rd;
    state_d     = state_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    overflow_d  = overflow_q;

    // Write-port priority: ALU result, then held load, then a fresh load.
    if (e1_valid_q) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = e1_rd_q;
      rf_wdata_d = alu_out;
    end else if (state_q == HELD) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = hold_rd_q;
      rf_wdata_d = hold_data_q;
    end else if (mem_valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_rd;
      rf_wdata_d = mem_data;
    end

    case (state_q)
      EMPTY: begin
        // A load colliding with the same-cycle ALU write is already stale.
        if (mem_valid && e1_valid_q && (e1_rd_q != mem_rd)) begin
          state_d     = HELD;
          hold_rd_d   = mem_rd;
          hold_data_d = mem_data;
        end
      end
      HELD: begin
        if (e1_valid_q) begin
          if (e1_rd_q == hold_rd_q) state_d = EMPTY;
          if (mem_valid) overflow_d = 1'b1;
        end else if (mem_valid) begin
          hold_rd_d   = mem_rd;
          hold_data_d = mem_data;
        end else begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q     <= EMPTY;
      e1_valid_q  <= 1'b0;
      e1_rd_q     <= '0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      e1_valid_q  <= e1_valid_d;
      e1_rd_q     <= e1_rd_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign fwd_valid = rf_we_q;
  assign fwd_reg   = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;
  assign overflow  = overflow_q;

endmodule
